// File: rtl/mips_multicycle_ctrl_if.sv
// Signal bundle between the multicycle MIPS controller and its datapath.
// The controller drives the master modport; the datapath/IR side uses slave.
interface mips_multicycle_ctrl_if;
    logic       en;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [2:0] aluOp;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       iorD;
    logic       irWrite;
    logic       memWrite;
    logic       regWrite;
    logic       regDst;
    logic       memToReg;
    logic       pcEn;
    logic [3:0] state;

    modport master (
        input  en, op, funct, zero,
        output aluOp, aluSrcA, aluSrcB, pcSrc, iorD, irWrite, memWrite,
               regWrite, regDst, memToReg, pcEn, state
    );

    modport slave (
        output en, op, funct, zero,
        input  aluOp, aluSrcA, aluSrcB, pcSrc, iorD, irWrite, memWrite,
               regWrite, regDst, memToReg, pcEn, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback and driving datapath selects, ALU op and write strobes.
module mips_multicycle_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic [2:0] rtype_aluop(input logic [5:0] f);
        case (f)
            6'b100000: rtype_aluop = ALU_ADD;
            6'b100010: rtype_aluop = ALU_SUB;
            6'b100100: rtype_aluop = ALU_AND;
            6'b100101: rtype_aluop = ALU_OR;
            6'b101010: rtype_aluop = ALU_SLT;
            default:   rtype_aluop = ALU_ADD;
        endcase
    endfunction

    function automatic logic rtype_known(input logic [5:0] f);
        rtype_known = (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
                      (f == 6'b100101) || (f == 6'b101010);
    endfunction

    state_t     r_state;
    state_t     w_next;
    logic       w_pcWrite;
    logic       w_branch;
    logic       w_irWrite;
    logic       w_memWrite;
    logic       w_regWrite;
    logic [2:0] w_aluOp;
    logic       w_aluSrcA;
    logic [1:0] w_aluSrcB;
    logic [1:0] w_pcSrc;
    logic       w_iorD;
    logic       w_regDst;
    logic       w_memToReg;
    logic       w_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_FETCH;
        else if (bus.en)
            r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:  w_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = S_MEMWB;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcWrite  = 1'b0;
        w_branch   = 1'b0;
        w_irWrite  = 1'b0;
        w_memWrite = 1'b0;
        w_regWrite = 1'b0;
        w_aluOp    = ALU_ADD;
        w_aluSrcA  = 1'b0;
        w_aluSrcB  = 2'b00;
        w_pcSrc    = 2'b00;
        w_iorD     = 1'b0;
        w_regDst   = 1'b0;
        w_memToReg = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_aluSrcB = 2'b01;
                w_irWrite = 1'b1;
                w_pcWrite = 1'b1;
            end
            S_DECODE:  w_aluSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                w_aluSrcA = 1'b1;
                w_aluSrcB = 2'b10;
            end
            S_MEMRD:   w_iorD = 1'b1;
            S_MEMWB: begin
                w_memToReg = 1'b1;
                w_regWrite = 1'b1;
            end
            S_MEMWR: begin
                w_iorD     = 1'b1;
                w_memWrite = 1'b1;
            end
            S_RTYPEEX: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = rtype_aluop(bus.funct);
            end
            // Unsupported funct codes write nothing back, turning the op into a NOP.
            S_RTYPEWB: begin
                w_regDst   = 1'b1;
                w_regWrite = rtype_known(bus.funct);
            end
            S_BEQEX: begin
                w_aluSrcA = 1'b1;
                w_aluOp   = ALU_SUB;
                w_pcSrc   = 2'b01;
                w_branch  = 1'b1;
            end
            S_ADDIWB:  w_regWrite = 1'b1;
            S_JEX: begin
                w_pcSrc   = 2'b10;
                w_pcWrite = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are also gated by rst_n so an asynchronous reset kills them at once.
    assign w_go = bus.en & rst_n;

    assign bus.state    = r_state;
    assign bus.aluOp    = w_aluOp;
    assign bus.aluSrcA  = w_aluSrcA;
    assign bus.aluSrcB  = w_aluSrcB;
    assign bus.pcSrc    = w_pcSrc;
    assign bus.iorD     = w_iorD;
    assign bus.regDst   = w_regDst;
    assign bus.memToReg = w_memToReg;
    assign bus.irWrite  = w_irWrite & w_go;
    assign bus.memWrite = w_memWrite & w_go;
    assign bus.regWrite = w_regWrite & w_go;
    assign bus.pcEn     = (w_pcWrite | (w_branch & bus.zero)) & w_go;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: an instruction-path reference model
// pushes the expected output word each cycle, a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;
    typedef struct packed {
        logic [3:0] state;
        logic [2:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] pcSrc;
        logic       iorD;
        logic       irWrite;
        logic       memWrite;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       pcEn;
    } out_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   idx = 0;
    out_t exp_q[$];

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Number of cycles each instruction class takes with en held high.
    function automatic int plen(input logic [5:0] o);
        case (o)
            LW:            return 5;
            SW, RT, ADDI:  return 4;
            BEQ, JMP:      return 3;
            default:       return 2;
        endcase
    endfunction

    // State visited at step i of the instruction with opcode o.
    function automatic int pstate(input logic [5:0] o, input int i);
        if (i < 2) return i;
        case (o)
            LW:      return i;
            SW:      return (i == 2) ? 2 : 5;
            RT:      return 4 + i;
            ADDI:    return 7 + i;
            BEQ:     return 8;
            JMP:     return 11;
            default: return 0;
        endcase
    endfunction

    function automatic out_t expect_out(input int st, input logic e, input logic rn,
                                        input logic [5:0] f, input logic z);
        out_t r;
        logic g;
        logic known;
        g     = e & rn;
        known = (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
        r.state = st[3:0];
        r.aluOp = 3'b010;
        if (st == 6) begin
            if (f == F_SUB) r.aluOp = 3'b110;
            else if (f == F_AND) r.aluOp = 3'b000;
            else if (f == F_OR) r.aluOp = 3'b001;
            else if (f == F_SLT) r.aluOp = 3'b111;
        end
        if (st == 8) r.aluOp = 3'b110;
        r.aluSrcA  = (st == 2) || (st == 9) || (st == 6) || (st == 8);
        r.aluSrcB  = (st == 0) ? 2'b01 : (st == 1) ? 2'b11 :
                     ((st == 2) || (st == 9)) ? 2'b10 : 2'b00;
        r.pcSrc    = (st == 8) ? 2'b01 : (st == 11) ? 2'b10 : 2'b00;
        r.iorD     = (st == 3) || (st == 5);
        r.irWrite  = g && (st == 0);
        r.memWrite = g && (st == 5);
        r.regWrite = g && ((st == 4) || (st == 10) || ((st == 7) && known));
        r.regDst   = (st == 7);
        r.memToReg = (st == 4);
        r.pcEn     = g && ((st == 0) || (st == 11) || ((st == 8) && z));
        return r;
    endfunction

    // One clock cycle: drive inputs, push the expected outputs, advance the model.
    task automatic cyc(input logic e, input logic rn, input logic [5:0] o,
                       input logic [5:0] f, input logic z);
        bus.en    = e;
        bus.op    = o;
        bus.funct = f;
        bus.zero  = z;
        rst_n     = rn;
        if (!rn) idx = 0;
        exp_q.push_back(expect_out(pstate(o, idx), e, rn, f, z));
        @(posedge clk);
        if (rn && e) begin
            idx = idx + 1;
            if (idx >= plen(o)) idx = 0;
        end
        #1;
    endtask

    // Run one instruction to completion; en drops for n_stall cycles at step stall_at.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                             input int stall_at, input int n_stall);
        int left;
        int guard;
        logic z;
        left  = n_stall;
        guard = 0;
        do begin
            z = (zmode == 2) ? logic'($urandom_range(0, 1)) : logic'(zmode == 1);
            if (idx == stall_at && left > 0) begin
                cyc(1'b0, 1'b1, o, f, z);
                left--;
            end else begin
                cyc(1'b1, 1'b1, o, f, z);
            end
            guard++;
        end while (idx != 0 && guard < 64);
    endtask

    always @(negedge clk) begin
        out_t act;
        out_t exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            act = '{bus.state, bus.aluOp, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.iorD,
                    bus.irWrite, bus.memWrite, bus.regWrite, bus.regDst, bus.memToReg,
                    bus.pcEn};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL ctrl_out t=%0t state=%0d: got %b, want %b", $time,
                         exp.state, act, exp);
            end
        end
    end

    initial begin
        logic [5:0] ops [7];
        logic [5:0] fs [6];
        logic [5:0] o;
        logic [5:0] f;
        int wait_n;
        ops = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b111111};
        fs  = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, 6'b111111};
        bus.en = 1'b0; bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
        @(posedge clk); #1;

        repeat (3) cyc(1'b1, 1'b0, LW, F_ADD, 1'b0);
        run_instr(LW, F_ADD, 0, -1, 0);
        run_instr(RT, F_SUB, 0, -1, 0);
        run_instr(RT, F_SLT, 0, -1, 0);
        run_instr(RT, 6'b111111, 0, -1, 0);
        run_instr(RT, F_AND, 0, -1, 0);
        run_instr(RT, F_OR, 0, -1, 0);
        run_instr(BEQ, F_ADD, 1, -1, 0);
        run_instr(BEQ, F_ADD, 0, -1, 0);
        run_instr(SW, F_ADD, 0, 3, 2);
        run_instr(6'b111111, F_ADD, 0, -1, 0);
        run_instr(JMP, F_ADD, 0, -1, 0);

        // Reset asserted while sitting in ADDIEX.
        cyc(1'b1, 1'b1, ADDI, F_ADD, 1'b0);
        cyc(1'b1, 1'b1, ADDI, F_ADD, 1'b0);
        cyc(1'b1, 1'b0, ADDI, F_ADD, 1'b0);
        cyc(1'b1, 1'b0, ADDI, F_ADD, 1'b0);
        run_instr(ADDI, F_ADD, 0, -1, 0);

        for (int n = 0; n < 300; n++) begin
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
            f = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fs[$urandom_range(0, 5)];
            for (int k = 0; k < 64; k++) begin
                if ($urandom_range(0, 49) == 0)
                    cyc(1'($urandom), 1'b0, o, f, 1'($urandom));
                else
                    cyc(logic'($urandom_range(0, 3) != 0), 1'b1, o, f, 1'($urandom));
                if (idx == 0) break;
            end
        end

        wait_n = 0;
        while (exp_q.size() > 0 && wait_n < 10) begin
            @(posedge clk);
            wait_n++;
        end
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle MIPS main controller: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath mux selects and write strobes, and drives the 3-bit `aluOp` into the ALU. It consumes the ALU `zero` flag to resolve `beq`. It sits between the instruction register (supplies `op`/`funct`) and the shared single-ALU datapath.

## Interface
- No parameters; the opcode, funct and aluOp encodings are fixed below.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `en` in 1: advance enable. When 0, state holds and all write strobes are 0.
- `op` in 6: instruction[31:26] from the instruction register.
- `funct` in 6: instruction[5:0] from the instruction register.
- `zero` in 1: ALU zero flag, same cycle.
- `aluOp` out 3: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `aluSrcA` out 1: 0 = PC, 1 = regA.
- `aluSrcB` out 2: 00 = regB, 01 = constant 4, 10 = signext(imm), 11 = signext(imm)<<2.
- `pcSrc` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `iorD` out 1: memory address source, 0 = PC, 1 = ALUOut.
- `irWrite`, `memWrite`, `regWrite` out 1 each: write strobes.
- `regDst` out 1: 0 = rt, 1 = rd.
- `memToReg` out 1: 0 = ALUOut, 1 = memory data register.
- `pcEn` out 1: `(pcWrite | (branch & zero)) & en`.
- `state` out 4: current state, for debug.

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12–15 are unreachable; if entered, go to FETCH on the next enabled edge.
- Transitions, taken only when `en`=1:
  - FETCH→DECODE.
  - DECODE→MEMADR (lw/sw), RTYPEEX, BEQEX, ADDIEX or JEX by `op`. Unknown `op`→FETCH (executes as a NOP).
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX→FETCH.
- Outputs per state. Any output not listed is 0, except `aluOp`, which is 010.
  - FETCH: aluSrcB=01, aluOp=010, irWrite=1, pcWrite=1.
  - DECODE: aluSrcB=11, aluOp=010.
  - MEMADR, ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=010.
  - MEMRD: iorD=1.
  - MEMWB: memToReg=1, regWrite=1.
  - MEMWR: iorD=1, memWrite=1.
  - RTYPEEX: aluSrcA=1, aluSrcB=00, aluOp from `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
  - RTYPEWB: regDst=1, regWrite=1. If `funct` is not one of the five above, regWrite=0 (result discarded).
  - BEQEX: aluSrcA=1, aluSrcB=00, aluOp=110, pcSrc=01, branch=1.
  - ADDIWB: regWrite=1.
  - JEX: pcSrc=10, pcWrite=1.
- `irWrite`, `memWrite`, `regWrite` and `pcEn` are all ANDed with `en`.

## Timing
- Outputs are Moore functions of `state`. The exceptions are `aluOp` in RTYPEEX, regWrite in RTYPEWB, and `pcEn` in BEQEX, which add a same-cycle dependence on `funct` or `zero`.
- Cycles per instruction with `en` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown op 2.
- Reset:
  - While `rst_n`=0, state=FETCH.
  - irWrite, memWrite, regWrite and pcEn are forced to 0. All other outputs hold their FETCH values.
  - Deassertion is synchronised externally. The first enabled edge after release goes FETCH→DECODE.
- Reset asserted mid-instruction aborts it immediately; no partial strobes are issued afterwards.
- `en`=0 for N cycles stretches the current state by N cycles. Mux selects and `aluOp` stay stable throughout.
- `op`/`funct` are sampled combinationally. They are stable from DECODE onward because irWrite is 1 only in FETCH.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → state=0, pcEn=0, irWrite=0, aluOp=010, aluSrcB=01. Release → state=1 after one edge.
- lw (op=100011), en=1 → state sequence 0,1,2,3,4,0. regWrite=1 and memToReg=1 only in state 4. iorD=1 only in state 3.
- R-type sub (funct=100010) → aluOp=110 in state 6, regDst=1 and regWrite=1 in state 7. Repeat with funct=101010 → aluOp=111. Repeat with funct=111111 → regWrite=0 in state 7.
- beq (op=000100):
  - zero=1 in state 8 → pcEn=1, pcSrc=01.
  - zero=0 → pcEn=0.
  - Next state is 0 in both cases.
- Stall: during sw state 5 (MEMWR), drop en for 2 cycles → state stays 5, memWrite=0 for those cycles, memWrite=1 on the enabled cycle, then state=0.
- Unknown op=111111 → 0,1,0 with no write strobes. Assert rst_n=0 during ADDIEX (state 9) → immediately state=0, regWrite never asserted.
